add_round_key_seq: RTL and testbench
====================================

// Module: add_round_key_seq
// PURPOSE
//   Parametrised, handshaked AddRoundKey stage for the AES datapath. Holds a local
//   round-key file (NUM_KEYS x BLOCK_W) and XORs a selected key into an accepted block.
//   The XOR is serialised over BLOCK_W/LANE_W beats, trading latency for XOR area.
//   Sits between the MixColumns/ShiftRows stage and the round-state register of the core.
// PARAMETERS
//   BLOCK_W  128  state/key width in bits
//   LANE_W   32   bits XORed per cycle; BLOCK_W % LANE_W == 0; BEATS = BLOCK_W/LANE_W
//   NUM_KEYS 15   round-key slots (15 covers AES-256)
//   KIDX_W   4    key index width; 2**KIDX_W >= NUM_KEYS
// PORTS
//   clk          in   1        clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   key_wr_en    in   1        write key_wr_data into slot key_wr_idx
//   key_wr_idx   in   KIDX_W   key slot to write
//   key_wr_data  in   BLOCK_W  round key value
//   in_valid     in   1        in_block/in_kidx valid
//   in_ready     out  1        stage can accept a block
//   in_block     in   BLOCK_W  input state
//   in_kidx      in   KIDX_W   round-key slot to apply
//   out_valid    out  1        out_block valid
//   out_ready    in   1        downstream accepts out_block
//   out_block    out  BLOCK_W  in_block ^ key[in_kidx]
//   busy         out  1        state != IDLE
//   key_err      out  1        one-cycle pulse: accepted in_kidx >= NUM_KEYS
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_block=0, busy=0,
//     key_err=0, beat counter=0, all key slots=0. Applies immediately, mid-operation too;
//     the in-flight block is discarded.
//   FSM IDLE -> XOR -> HOLD -> IDLE. in_ready = (state==IDLE); out_valid = (state==HOLD).
//   IDLE: accept on edge N when in_valid&&in_ready. Latch in_block into the work register.
//     Copy key[in_kidx] into the key register. Beat counter=0. Go to XOR.
//   XOR: edges N+1..N+BEATS each XOR lane b (lane 0 = bits [LANE_W-1:0], ascending).
//     At beat BEATS-1: go to HOLD, out_valid=1 from edge N+BEATS. Latency = BEATS cycles
//     (LANE_W=BLOCK_W gives 1-cycle latency).
//   HOLD: out_block, out_valid stable until out_valid&&out_ready (edge M). Then go to
//     IDLE, in_ready=1 from M. No accept in HOLD.
//     Max throughput: 1 block per BEATS+2 cycles.
//   out_block updates only on the HOLD entry edge. It holds its last value in IDLE/XOR.
//   Key file: key_wr_en with key_wr_idx < NUM_KEYS writes on the clock edge.
//     Writes are allowed in any state. key_wr_idx >= NUM_KEYS: write ignored.
//   Write and accept to the same slot on the same edge: the accepted block uses the OLD key.
//   Writes after accept do not affect the in-flight block; the key is snapshotted.
//   in_kidx >= NUM_KEYS at accept: key snapshot = 0 (block passes unchanged). key_err=1
//     for exactly the cycle after the accept edge.
//   in_valid while in_ready=0: ignored. in_block/in_kidx need not be held.
//   Widths: pure bitwise XOR, no carries. out_block width = BLOCK_W.
// TESTING
//   1 FIPS-197: key0=000102030405060708090a0b0c0d0e0f, in_block=00112233445566778899aabbccddeeff,
//     kidx 0 -> out_block=00102030405060708090a0b0c0d0e0f0, out_valid exactly 4 cycles after accept.
//   2 Backpressure: out_ready=0 for 10 cycles -> out_valid=1, out_block stable, in_ready=0.
//     out_ready=1 -> in_ready=1 next cycle.
//   3 Key hazard: rewrite slot 0 with all-ones on the accept edge and again in XOR ->
//     result uses the old key. The next block uses all-ones.
//   4 in_kidx=15 (NUM_KEYS=15), in_block=deadbeef... -> out_block==in_block, key_err high
//     one cycle. key_wr_idx=15 -> no slot changes.
//   5 Reset asserted during XOR beat 2 -> out_valid=0, busy=0 at once, in_ready=1.
//     Next block with kidx 3 passes unchanged (keys zeroed).
//   6 208 random blocks/keys/kidx, random in_valid/out_ready vs XOR model -> 0 mismatches.
//     Repeat with LANE_W=128 (latency 1) and LANE_W=8 (latency 16).

Source files
------------

// File: rtl/add_round_key_seq.sv
// add_round_key_seq: handshaked AES AddRoundKey stage, key XOR serialised over LANE_W-bit beats
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   key_wr_en/idx/data      round-key file write port; idx >= NUM_KEYS is ignored
//   in_valid/in_ready       input handshake for in_block and in_kidx
//   in_block, in_kidx       state to transform and the key slot to apply to it
//   out_valid/out_ready     output handshake; out_block = in_block ^ key[in_kidx]
//   busy                    high whenever a block is in flight or being held
//   key_err                 one-cycle pulse after accepting an out-of-range in_kidx
module add_round_key_seq #(
  parameter int BLOCK_W  = 128,
  parameter int LANE_W   = 32,
  parameter int NUM_KEYS = 15,
  parameter int KIDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_wr_en,
  input  logic [KIDX_W-1:0]  key_wr_idx,
  input  logic [BLOCK_W-1:0] key_wr_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic [KIDX_W-1:0]  in_kidx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy,
  output logic               key_err
);
  localparam int BEATS  = BLOCK_W / LANE_W;
  localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, XOR, HOLD} state_t;
  state_t r_state, w_state_nxt;
  logic [BLOCK_W-1:0] r_keys [NUM_KEYS];
  logic [BLOCK_W-1:0] r_work, r_key, r_out;
  logic [BEAT_W-1:0]  r_beat;
  logic               r_key_err;
  logic               w_accept, w_last, w_kidx_ok, w_wr_ok;
  logic [BLOCK_W-1:0] w_lane_xor, w_work_nxt, w_key_nxt;
  assign w_kidx_ok  = int'(in_kidx) < NUM_KEYS;
  assign w_wr_ok    = key_wr_en && int'(key_wr_idx) < NUM_KEYS;
  assign w_last     = r_beat == BEAT_W'(BEATS - 1);
  // Work and key registers rotate right one lane per beat, so only lane 0 needs an XOR.
  // After BEATS rotations every lane has been XORed once and the block is back in place.
  assign w_lane_xor = r_work ^ BLOCK_W'(r_key[LANE_W-1:0]);
  assign w_work_nxt = (w_lane_xor >> LANE_W) | (w_lane_xor << (BLOCK_W - LANE_W));
  assign w_key_nxt  = (r_key >> LANE_W) | (r_key << (BLOCK_W - LANE_W));
  assign out_block  = r_out;
  assign key_err    = r_key_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = r_state == IDLE;
    out_valid   = r_state == HOLD;
    busy        = r_state != IDLE;
    w_accept    = in_ready && in_valid;
    w_state_nxt = r_state == IDLE ? (in_valid ? XOR : IDLE) :
                  r_state == XOR  ? (w_last ? HOLD : XOR) :
                  (out_ready ? IDLE : HOLD);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_work    <= '0;
      r_key     <= '0;
      r_out     <= '0;
      r_beat    <= '0;
      r_key_err <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) r_keys[k] <= '0;
    end else begin
      // The key is snapshotted here; a same-edge write lands after this read (old key wins).
      if (w_accept) begin
        r_work <= in_block;
        r_key  <= w_kidx_ok ? r_keys[in_kidx] : '0;
        r_beat <= '0;
      end else if (r_state == XOR) begin
        r_work <= w_work_nxt;
        r_key  <= w_key_nxt;
        r_beat <= r_beat + 1'b1;
        if (w_last) r_out <= w_work_nxt;
      end
      r_key_err <= w_accept && !w_kidx_ok;
      if (w_wr_ok) r_keys[key_wr_idx] <= key_wr_data;
    end
endmodule

// File: tb/tb_add_round_key_seq.sv
// tb_add_round_key_seq: directed vectors plus randomized model checks for add_round_key_seq
module tb_add_round_key_seq;
  localparam int BEATS = 4;
  typedef struct {
    logic [127:0] blk;
    logic [127:0] key;
    logic [3:0]   kidx;
    logic [127:0] exp;
    logic         err;
  } vec_t;
  logic         clk;
  logic         rst_n, key_wr_en, in_valid, in_ready, out_valid, out_ready, busy, key_err;
  logic [3:0]   key_wr_idx, in_kidx;
  logic [127:0] key_wr_data, in_block, out_block;
  int           checks, errors, rdone;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  add_round_key_seq u_dut (
    .clk(clk), .rst_n(rst_n), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_kidx(in_kidx), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy), .key_err(key_err)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic wr_key(input logic [3:0] idx, input logic [127:0] data);
    key_wr_en = 1'b1;
    key_wr_idx = idx;
    key_wr_data = data;
    @(negedge clk);
    key_wr_en = 1'b0;
  endtask
  task automatic send(input logic [127:0] blk, input logic [3:0] kidx, input logic err);
    int lat;
    in_valid = 1'b1;
    in_block = blk;
    in_kidx = kidx;
    @(negedge clk);
    in_valid = 1'b0;
    in_block = rnd128();
    in_kidx = 4'($urandom_range(15));
    chk("key_err_at_accept", key_err, err);
    chk("busy_after_accept", busy, 1'b1);
    chk("in_ready_after_accept", in_ready, 1'b0);
    @(negedge clk);
    chk("key_err_one_cycle", key_err, 1'b0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, BEATS);
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_release", in_ready, 1'b1);
    chk("out_valid_after_release", out_valid, 1'b0);
  endtask
  initial begin
    vec_t         tv [5];
    logic [127:0] fips_key, b;
    checks = 0;
    errors = 0;
    fips_key = 128'h000102030405060708090a0b0c0d0e0f;
    tv[0] = '{128'h00112233445566778899aabbccddeeff, fips_key, 4'd0,
              128'h00102030405060708090a0b0c0d0e0f0, 1'b0};
    tv[1] = '{{16{8'h0f}}, {16{8'hff}}, 4'd7, {16{8'hf0}}, 1'b0};
    tv[2] = '{{16{8'ha5}}, {16{8'ha5}}, 4'd14, 128'h0, 1'b0};
    tv[3] = '{128'h0, 128'h0123456789abcdeffedcba9876543210, 4'd1,
              128'h0123456789abcdeffedcba9876543210, 1'b0};
    tv[4] = '{{4{32'hdeadbeef}}, {16{8'h77}}, 4'd15, {4{32'hdeadbeef}}, 1'b1};
    rst_n = 1'b0;
    key_wr_en = 1'b0;
    key_wr_idx = '0;
    key_wr_data = '0;
    in_valid = 1'b0;
    in_block = '0;
    in_kidx = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_block", out_block, 128'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_key_err", key_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (tv[i].kidx < 4'd15) wr_key(tv[i].kidx, tv[i].key);
      send(tv[i].blk, tv[i].kidx, tv[i].err);
      chk($sformatf("vec%0d_out_block", i), out_block, tv[i].exp);
      release_out();
    end
    b = rnd128();
    send(b, 4'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_block", out_block, b ^ 128'h0123456789abcdeffedcba9876543210);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    release_out();
    b = rnd128();
    key_wr_en = 1'b1;
    key_wr_idx = 4'd0;
    key_wr_data = '1;
    send(b, 4'd0, 1'b0);
    key_wr_en = 1'b0;
    chk("hazard_old_key", out_block, b ^ fips_key);
    release_out();
    b = rnd128();
    send(b, 4'd0, 1'b0);
    chk("hazard_new_key", out_block, ~b);
    release_out();
    wr_key(4'd15, 128'h1);
    send({4{32'hdeadbeef}}, 4'd15, 1'b1);
    chk("kidx15_passthru", out_block, {4{32'hdeadbeef}});
    release_out();
    b = rnd128();
    send(b, 4'd14, 1'b0);
    chk("wr_idx15_ignored", out_block, b ^ {16{8'ha5}});
    release_out();
    wr_key(4'd3, rnd128());
    in_valid = 1'b1;
    in_block = rnd128();
    in_kidx = 4'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_block", out_block, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b = rnd128();
    send(b, 4'd3, 1'b0);
    chk("midrst_keys_zeroed", out_block, b);
    release_out();
    for (int t = 0; t < 40000 && rdone < 3; t++) @(negedge clk);
    chk("random_runs_finished", rdone, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial rdone = 0;
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int LW = g == 0 ? 32 : g == 1 ? 128 : 8;
    localparam int NB = 128 / LW;
    logic         r_n, we, iv, ir, ov, ordy, bz, ke;
    logic [3:0]   wi, ki;
    logic [127:0] wd, ib, ob;
    logic [127:0] mk [15];
    logic [127:0] mexp, mout;
    logic         mb, merr;
    int           cyc, rdy, acc, c;
    add_round_key_seq #(.LANE_W(LW)) u_rnd (
      .clk(clk), .rst_n(r_n), .key_wr_en(we), .key_wr_idx(wi), .key_wr_data(wd),
      .in_valid(iv), .in_ready(ir), .in_block(ib), .in_kidx(ki), .out_valid(ov),
      .out_ready(ordy), .out_block(ob), .busy(bz), .key_err(ke)
    );
    initial begin
      r_n = 1'b0;
      we = 1'b0;
      iv = 1'b0;
      ordy = 1'b0;
      wi = '0;
      ki = '0;
      wd = '0;
      ib = '0;
      for (int k = 0; k < 15; k++) mk[k] = '0;
      mb = 1'b0;
      merr = 1'b0;
      mexp = '0;
      mout = '0;
      cyc = 0;
      rdy = 0;
      acc = 0;
      repeat (2) @(negedge clk);
      r_n = 1'b1;
      for (int t = 0; t < 20000; t++) begin
        @(negedge clk);
        if (mb && cyc >= rdy) mout = mexp;
        chk($sformatf("rnd%0d_in_ready", LW), ir, !mb);
        chk($sformatf("rnd%0d_out_valid", LW), ov, mb && cyc >= rdy);
        chk($sformatf("rnd%0d_busy", LW), bz, mb);
        chk($sformatf("rnd%0d_key_err", LW), ke, merr);
        chk($sformatf("rnd%0d_out_block", LW), ob, mout);
        if (acc == 208 && !mb) break;
        iv = acc < 208 && $urandom_range(9) < 6;
        ib = rnd128();
        ki = 4'($urandom_range(15));
        ordy = $urandom_range(9) < 7;
        we = $urandom_range(9) < 3;
        wi = 4'($urandom_range(15));
        wd = rnd128();
        @(posedge clk);
        c = cyc;
        cyc++;
        merr = 1'b0;
        if (mb && c >= rdy) begin
          if (ordy) mb = 1'b0;
        end else if (!mb && iv) begin
          mb = 1'b1;
          mexp = ki < 4'd15 ? ib ^ mk[ki] : ib;
          merr = ki == 4'd15;
          rdy = cyc + NB;
          acc++;
        end
        if (we && wi < 4'd15) mk[wi] = wd;
      end
      chk($sformatf("rnd%0d_blocks_done", LW), acc, 208);
      chk($sformatf("rnd%0d_drained", LW), mb, 1'b0);
      rdone++;
    end
  end
endmodule
